// File: rtl/gshare_bht.sv
// gshare_bht: gshare branch direction predictor with a speculative global
// history register, mispredict history repair and a row-by-row table-clear
// sequencer that runs after reset and on every flush.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_bp_i             restart the table clear (also clears the GHR)
//   debug_mode_i           freeze counter and history updates, mask predictions
//   vpc_i                  fetch PC used for the prediction lookup
//   pred_valid_o           per-slot prediction valid
//   pred_taken_o           per-slot predicted direction (counter MSB)
//   pred_index_o           row index used by this lookup (carry to resolution)
//   pred_ghr_o             history used by this lookup (carry to resolution)
//   spec_valid_i/_taken_i  speculative history push
//   upd_*_i                resolved-branch counter update and history repair
//   busy_o                 table clear in progress
module gshare_bht #(
   parameter  int unsigned VLEN            = 64,
   parameter  int unsigned INSTR_PER_FETCH = 2,
   parameter  int unsigned NR_ENTRIES      = 1024,
   parameter  int unsigned HIST_BITS       = 9,
   parameter  int unsigned CTR_BITS        = 2,
   localparam int unsigned NR_ROWS         = NR_ENTRIES / INSTR_PER_FETCH,
   localparam int unsigned ROW_BITS        = $clog2(NR_ROWS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_bp_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
   output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
   output logic [ROW_BITS-1:0]        pred_index_o,
   output logic [HIST_BITS-1:0]       pred_ghr_o,
   input  logic                       spec_valid_i,
   input  logic                       spec_taken_i,
   input  logic                       upd_valid_i,
   input  logic [VLEN-1:0]            upd_pc_i,
   input  logic                       upd_taken_i,
   input  logic [ROW_BITS-1:0]        upd_index_i,
   input  logic [HIST_BITS-1:0]       upd_ghr_i,
   input  logic                       upd_mispredict_i,
   output logic                       busy_o
);

   localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
   localparam int unsigned OFFSET   = 1 + COL_BITS;

   localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [ROW_BITS-1:0] LAST_ROW    = ROW_BITS'(NR_ROWS - 1);

   // Elaboration-time parameter sanity
   if (HIST_BITS > ROW_BITS || HIST_BITS < 2) begin : g_bad_hist
      $error("gshare_bht: HIST_BITS must be in [2, ROW_BITS]");
   end
   if (INSTR_PER_FETCH < 2 || (1 << COL_BITS) != INSTR_PER_FETCH) begin : g_bad_ipf
      $error("gshare_bht: INSTR_PER_FETCH must be a power of 2 and at least 2");
   end
   if ((1 << ROW_BITS) != NR_ROWS || CTR_BITS < 1 || VLEN <= OFFSET + ROW_BITS) begin : g_bad_geom
      $error("gshare_bht: invalid table geometry");
   end

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ROW_BITS-1:0]  clr_ptr_q, clr_ptr_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;

   // Counter table: asynchronous read, contents undefined until the sweep ends
   logic [CTR_BITS-1:0]  ctr_q [NR_ROWS][INSTR_PER_FETCH];

   logic                 run_en;
   logic                 clr_we;
   logic                 upd_we;
   logic [ROW_BITS-1:0]  pred_row;
   logic [COL_BITS-1:0]  upd_col;
   logic [CTR_BITS-1:0]  ctr_old;
   logic [CTR_BITS-1:0]  ctr_new;

   assign run_en   = (state_q == S_RUN) && !debug_mode_i;
   assign clr_we   = (state_q == S_CLEAR);
   assign upd_we   = upd_valid_i && run_en;
   assign pred_row = vpc_i[OFFSET+ROW_BITS-1:OFFSET] ^ ROW_BITS'(ghr_q);
   assign upd_col  = upd_pc_i[OFFSET-1:1];
   assign ctr_old  = ctr_q[upd_index_i][upd_col];

   // PC bits outside the index/column fields and the oldest history bit are not needed
   logic unused_bits;
   assign unused_bits = ^{vpc_i[VLEN-1:OFFSET+ROW_BITS], vpc_i[0],
                          upd_pc_i[VLEN-1:OFFSET], upd_pc_i[0],
                          upd_ghr_i[HIST_BITS-1]};

   // Prediction outputs
   always_comb begin
      pred_taken_o = '0;
      for (int unsigned s = 0; s < INSTR_PER_FETCH; s++) begin
         pred_taken_o[s] = ctr_q[pred_row][COL_BITS'(s)][CTR_BITS-1];
      end
   end

   assign pred_valid_o = {INSTR_PER_FETCH{run_en}};
   assign pred_index_o = pred_row;
   assign pred_ghr_o   = ghr_q;
   assign busy_o       = (state_q == S_CLEAR);

   // Saturating counter step for the resolved branch
   always_comb begin
      ctr_new = ctr_old;
      if (upd_taken_i) begin
         if (ctr_old != CTR_MAX) ctr_new = ctr_old + CTR_BITS'(1);
      end else begin
         if (ctr_old != '0) ctr_new = ctr_old - CTR_BITS'(1);
      end
   end

   // Table write port: whole-row clear takes precedence over single-entry update
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
            ctr_q[clr_ptr_q][COL_BITS'(c)] <= CTR_WEAK_NT;
         end
      end else if (upd_we) begin
         ctr_q[upd_index_i][upd_col] <= ctr_new;
      end
   end

   // State, sweep pointer and history registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_CLEAR;
         clr_ptr_q <= '0;
         ghr_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         ghr_q     <= ghr_d;
      end
   end

   // Next-state: sweep sequencing, history repair over speculative push, flush override
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      ghr_d     = ghr_q;

      unique case (state_q)
         S_CLEAR: begin
            if (clr_ptr_q == LAST_ROW) begin
               state_d   = S_RUN;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + ROW_BITS'(1);
            end
         end
         S_RUN: begin
            if (!debug_mode_i) begin
               if (upd_valid_i && upd_mispredict_i) begin
                  ghr_d = {upd_ghr_i[HIST_BITS-2:0], upd_taken_i};
               end else if (spec_valid_i) begin
                  ghr_d = {ghr_q[HIST_BITS-2:0], spec_taken_i};
               end
            end
         end
         default: begin
            state_d   = S_CLEAR;
            clr_ptr_d = '0;
         end
      endcase

      if (flush_bp_i) begin
         state_d   = S_CLEAR;
         clr_ptr_d = '0;
         ghr_d     = '0;
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed self-checking bench for gshare_bht (default parameters).
module tb_gshare_bht;

   localparam int unsigned VLEN = 64;
   localparam int unsigned IPF  = 2;
   localparam int unsigned RB   = 9;
   localparam int unsigned HB   = 9;

   logic            clk_i;
   logic            rst_ni;
   logic            flush_bp_i;
   logic            debug_mode_i;
   logic [VLEN-1:0] vpc_i;
   logic [IPF-1:0]  pred_valid_o;
   logic [IPF-1:0]  pred_taken_o;
   logic [RB-1:0]   pred_index_o;
   logic [HB-1:0]   pred_ghr_o;
   logic            spec_valid_i;
   logic            spec_taken_i;
   logic            upd_valid_i;
   logic [VLEN-1:0] upd_pc_i;
   logic            upd_taken_i;
   logic [RB-1:0]   upd_index_i;
   logic [HB-1:0]   upd_ghr_i;
   logic            upd_mispredict_i;
   logic            busy_o;

   int errors = 0;
   int checks = 0;

   gshare_bht #(
      .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .NR_ENTRIES(1024), .HIST_BITS(HB), .CTR_BITS(2)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
      .vpc_i(vpc_i), .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
      .pred_index_o(pred_index_o), .pred_ghr_o(pred_ghr_o),
      .spec_valid_i(spec_valid_i), .spec_taken_i(spec_taken_i),
      .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
      .upd_index_i(upd_index_i), .upd_ghr_i(upd_ghr_i), .upd_mispredict_i(upd_mispredict_i),
      .busy_o(busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   function automatic logic [VLEN-1:0] vpc_for(input logic [RB-1:0] row, input logic slot);
      return VLEN'({row, slot, 1'b0});
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic look(input logic [RB-1:0] row, input logic slot);
      vpc_i = vpc_for(row, slot);
      #1;
   endtask

   task automatic spec_push(input logic t);
      spec_valid_i = 1'b1;
      spec_taken_i = t;
      tick();
      spec_valid_i = 1'b0;
      spec_taken_i = 1'b0;
   endtask

   task automatic update(input logic [RB-1:0] idx, input logic slot, input logic t,
                         input logic mp, input logic [HB-1:0] ghr);
      upd_valid_i      = 1'b1;
      upd_index_i      = idx;
      upd_pc_i         = VLEN'({slot, 1'b0});
      upd_taken_i      = t;
      upd_mispredict_i = mp;
      upd_ghr_i        = ghr;
      tick();
      upd_valid_i      = 1'b0;
      upd_mispredict_i = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      logic [VLEN-1:0] pcs [3];
      pcs = '{64'h0, 64'h40, 64'h1234_5678_9abc_def6};
      rst_ni = 1'b0;
      repeat (3) tick();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy_o); end
      checks++; if (pred_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", pred_valid_o); end
      checks++; if (pred_ghr_o !== 9'h000) begin errors++; $display("FAIL reset_ghr: got %h expected 000", pred_ghr_o); end
      rst_ni = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         if (n == 100) begin
            checks++; if (pred_valid_o !== 2'b00) begin errors++; $display("FAIL clear_valid: got %b expected 00", pred_valid_o); end
         end
      end while (busy_o && n < 2000);
      checks++; if (n != 512) begin errors++; $display("FAIL reset_clear_cycles: got %0d expected 512", n); end
      foreach (pcs[i]) begin
         vpc_i = pcs[i];
         #1;
         checks++; if (pred_valid_o !== 2'b11) begin errors++; $display("FAIL run_valid[%0d]: got %b expected 11", i, pred_valid_o); end
         checks++; if (pred_taken_o !== 2'b00) begin errors++; $display("FAIL run_weak_nt[%0d]: got %b expected 00", i, pred_taken_o); end
      end
   endtask

   task automatic test_saturation();
      look(9'h010, 1'b0);
      repeat (3) update(9'h010, 1'b0, 1'b1, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b1) begin errors++; $display("FAIL sat_3taken: got %b expected 1", pred_taken_o[0]); end
      update(9'h010, 1'b0, 1'b1, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b1) begin errors++; $display("FAIL sat_ceiling: got %b expected 1", pred_taken_o[0]); end
      update(9'h010, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b1) begin errors++; $display("FAIL sat_nt1: got %b expected 1", pred_taken_o[0]); end
      update(9'h010, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b0) begin errors++; $display("FAIL sat_nt2: got %b expected 0", pred_taken_o[0]); end
      repeat (2) update(9'h010, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b0) begin errors++; $display("FAIL sat_floor: got %b expected 0", pred_taken_o[0]); end
      update(9'h010, 1'b0, 1'b1, 1'b0, '0);
      checks++; if (pred_taken_o[0] !== 1'b0) begin errors++; $display("FAIL sat_inc_from_floor: got %b expected 0", pred_taken_o[0]); end
      // second taken (01 -> 10): old value visible until the edge
      upd_valid_i = 1'b1; upd_index_i = 9'h010; upd_pc_i = '0; upd_taken_i = 1'b1;
      #1;
      checks++; if (pred_taken_o[0] !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %b expected 0", pred_taken_o[0]); end
      tick();
      upd_valid_i = 1'b0;
      checks++; if (pred_taken_o !== 2'b01) begin errors++; $display("FAIL sat_after_write: got %b expected 01", pred_taken_o); end
   endtask

   task automatic test_spec_history();
      spec_push(1'b1);
      spec_push(1'b1);
      spec_push(1'b0);
      checks++; if (pred_ghr_o !== 9'h006) begin errors++; $display("FAIL spec_ghr: got %h expected 006", pred_ghr_o); end
      look(9'h005, 1'b0);
      checks++; if (pred_index_o !== 9'h003) begin errors++; $display("FAIL spec_index: got %h expected 003", pred_index_o); end
      look(9'h016, 1'b1);
      checks++; if (pred_index_o !== 9'h010) begin errors++; $display("FAIL hashed_index: got %h expected 010", pred_index_o); end
      checks++; if (pred_taken_o !== 2'b01) begin errors++; $display("FAIL hashed_taken: got %b expected 01", pred_taken_o); end
   endtask

   task automatic test_repair();
      spec_valid_i = 1'b1; spec_taken_i = 1'b0;
      update(9'h100, 1'b1, 1'b1, 1'b1, 9'h0f0);
      spec_valid_i = 1'b0;
      checks++; if (pred_ghr_o !== 9'h1e1) begin errors++; $display("FAIL repair_ghr: got %h expected 1e1", pred_ghr_o); end
      look(9'h0e1, 1'b0);
      checks++; if (pred_index_o !== 9'h100) begin errors++; $display("FAIL repair_index: got %h expected 100", pred_index_o); end
      checks++; if (pred_taken_o !== 2'b10) begin errors++; $display("FAIL repair_ctr: got %b expected 10", pred_taken_o); end
      update(9'h1f0, 1'b0, 1'b0, 1'b1, 9'h1ff);
      checks++; if (pred_ghr_o !== 9'h1fe) begin errors++; $display("FAIL repair_nt_ghr: got %h expected 1fe", pred_ghr_o); end
      spec_valid_i = 1'b1; spec_taken_i = 1'b1;
      update(9'h1f0, 1'b0, 1'b0, 1'b0, 9'h055);
      spec_valid_i = 1'b0;
      checks++; if (pred_ghr_o !== 9'h1fd) begin errors++; $display("FAIL spec_with_update: got %h expected 1fd", pred_ghr_o); end
   endtask

   task automatic test_flush_mid_clear();
      int n;
      flush_bp_i = 1'b1;
      tick();
      flush_bp_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b expected 1", busy_o); end
      checks++; if (pred_ghr_o !== 9'h000) begin errors++; $display("FAIL flush_ghr: got %h expected 000", pred_ghr_o); end
      repeat (100) tick();
      flush_bp_i = 1'b1;
      tick();
      flush_bp_i = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy_o && n < 2000);
      checks++; if (n != 512) begin errors++; $display("FAIL flush_restart_cycles: got %0d expected 512", n); end
      look(9'h010, 1'b0);
      checks++; if (pred_taken_o !== 2'b00) begin errors++; $display("FAIL flush_row010: got %b expected 00", pred_taken_o); end
      look(9'h100, 1'b0);
      checks++; if (pred_taken_o !== 2'b00) begin errors++; $display("FAIL flush_row100: got %b expected 00", pred_taken_o); end
      update(9'h010, 1'b0, 1'b1, 1'b0, '0);
      look(9'h010, 1'b0);
      checks++; if (pred_taken_o !== 2'b01) begin errors++; $display("FAIL flush_weak_nt: got %b expected 01", pred_taken_o); end
   endtask

   task automatic test_debug_freeze();
      spec_push(1'b1);
      look(9'h011, 1'b0);
      checks++; if (pred_taken_o !== 2'b01) begin errors++; $display("FAIL pre_freeze_taken: got %b expected 01", pred_taken_o); end
      debug_mode_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         spec_valid_i = 1'b1; spec_taken_i = 1'b1;
         upd_valid_i = 1'b1; upd_index_i = 9'h020; upd_pc_i = 64'h2; upd_taken_i = 1'b1;
         upd_mispredict_i = 1'(i % 2); upd_ghr_i = 9'h0aa;
         tick();
         if (i == 0 || i == 19) begin
            checks++; if (pred_valid_o !== 2'b00) begin errors++; $display("FAIL debug_valid[%0d]: got %b expected 00", i, pred_valid_o); end
            checks++; if (pred_ghr_o !== 9'h001) begin errors++; $display("FAIL debug_ghr[%0d]: got %h expected 001", i, pred_ghr_o); end
         end
      end
      spec_valid_i = 1'b0; upd_valid_i = 1'b0; upd_mispredict_i = 1'b0; debug_mode_i = 1'b0;
      look(9'h011, 1'b0);
      checks++; if (pred_valid_o !== 2'b11) begin errors++; $display("FAIL post_freeze_valid: got %b expected 11", pred_valid_o); end
      checks++; if (pred_taken_o !== 2'b01) begin errors++; $display("FAIL post_freeze_taken: got %b expected 01", pred_taken_o); end
      look(9'h021, 1'b1);
      checks++; if (pred_taken_o !== 2'b00) begin errors++; $display("FAIL post_freeze_row020: got %b expected 00", pred_taken_o); end
   endtask

   task automatic test_reset_mid();
      int n;
      spec_push(1'b1);
      rst_ni = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL async_reset_busy: got %b expected 1", busy_o); end
      checks++; if (pred_ghr_o !== 9'h000) begin errors++; $display("FAIL async_reset_ghr: got %h expected 000", pred_ghr_o); end
      #1;
      rst_ni = 1'b1;
      spec_valid_i = 1'b1; spec_taken_i = 1'b1;
      upd_valid_i = 1'b1; upd_index_i = 9'h000; upd_pc_i = '0; upd_taken_i = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy_o && n < 2000);
      spec_valid_i = 1'b0; upd_valid_i = 1'b0;
      checks++; if (n != 512) begin errors++; $display("FAIL reset_mid_cycles: got %0d expected 512", n); end
      checks++; if (pred_ghr_o !== 9'h000) begin errors++; $display("FAIL clear_drops_spec: got %h expected 000", pred_ghr_o); end
      look(9'h000, 1'b0);
      checks++; if (pred_taken_o !== 2'b00) begin errors++; $display("FAIL clear_drops_update: got %b expected 00", pred_taken_o); end
   endtask

   initial begin
      rst_ni = 1'b0; flush_bp_i = 1'b0; debug_mode_i = 1'b0; vpc_i = '0;
      spec_valid_i = 1'b0; spec_taken_i = 1'b0;
      upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_index_i = '0;
      upd_ghr_i = '0; upd_mispredict_i = 1'b0;
      test_reset();
      test_saturation();
      test_spec_history();
      test_repair();
      test_flush_mid_clear();
      test_debug_freeze();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
